// File: rtl/npu_act_pkg.sv
// ============================================================================
// Module      : npu_act_pkg
// Description : Shared types and the activation helper for the NPU
//               activation path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npu_act_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ACT_DATA_W = 22;

    // Plain ReLU on a two's-complement pixel.
    function automatic logic [ACT_DATA_W-1:0] relu_f(input logic [ACT_DATA_W-1:0] pixel);
        return pixel[ACT_DATA_W-1] ? '0 : pixel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/relu_stage.sv
// ============================================================================
// Module      : relu_stage
// Description : Combinational ReLU with optional positive clip.
//               Optional feature macro: ACT_SAT_EN (clip at SAT_MAX).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module relu_stage
    import npu_act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W
`ifdef ACT_SAT_EN
    ,
    parameter int SAT_MAX = (1 << 20) - 1
`endif
) (
    input  logic [DATA_W-1:0] i_pixel,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] w_relu;

    if (DATA_W == ACT_DATA_W) begin : g_pkg_relu
        assign w_relu = relu_f(i_pixel);
    end else begin : g_generic_relu
        assign w_relu = i_pixel[DATA_W-1] ? '0 : i_pixel;
    end

`ifdef ACT_SAT_EN
    localparam logic [DATA_W-1:0] C_SAT = DATA_W'(SAT_MAX);

    // w_relu is never negative here, so an unsigned compare is exact.
    assign o_result = (w_relu > C_SAT) ? C_SAT : w_relu;
`else
    assign o_result = w_relu;
`endif

endmodule

`default_nettype wire

// File: rtl/act_arbiter_ctrl.sv
// ============================================================================
// Module      : act_arbiter_ctrl
// Description : Frame-locked round-robin arbiter sharing one ReLU stage among
//               N_REQ streams, with tagged valid/ready output register and
//               frame length checking. Optional macro: ACT_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_arbiter_ctrl
    import npu_act_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = ACT_DATA_W,
    parameter int FRAME_LEN = 1024,
    parameter int SAT_MAX   = (1 << 20) - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0]  out_tag,
    output logic                      out_last,
    output logic                      frame_done,
    output logic                      len_err
);

    localparam int                TAG_W       = $clog2(N_REQ);
    localparam int                CNT_W       = $clog2(FRAME_LEN) + 1;
    localparam logic [TAG_W-1:0]  C_LAST_ID   = TAG_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0]  C_FRAME_LEN = CNT_W'(FRAME_LEN);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("act_arbiter_ctrl: N_REQ must be in 2..8");
    end
    if (SAT_MAX < 1 || SAT_MAX >= (1 << (DATA_W - 1))) begin : g_bad_sat_max
        $error("act_arbiter_ctrl: SAT_MAX must be a positive in-range value");
    end

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [TAG_W-1:0]   r_owner;
    logic [TAG_W-1:0]   r_rr_ptr;
    logic [TAG_W-1:0]   w_pick_id;
    logic               w_pick_vld;
    logic               w_owner_rdy;
    logic               w_xfer;
    logic               w_xfer_last;
    logic [DATA_W-1:0]  w_req_pix [N_REQ];
    logic [DATA_W-1:0]  w_act_data;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic               r_len_err;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_last;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req_unpack
        assign w_req_pix[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        logic [TAG_W-1:0] v_id;
        w_pick_vld = 1'b0;
        w_pick_id  = '0;
        v_id       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_id = TAG_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (req_valid[v_id]) begin
                w_pick_vld = 1'b1;
                w_pick_id  = v_id;
            end
        end
    end

    assign w_owner_rdy = !r_out_valid || out_ready;
    assign w_xfer      = (r_state == ARB_BUSY) && req_valid[r_owner] && w_owner_rdy;
    assign w_xfer_last = w_xfer && req_last[r_owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                req_ready[r_owner] = w_owner_rdy;
                if (w_xfer_last) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_pix_cnt <= '0;
            r_len_err <= 1'b0;
        end else begin
            if (r_state == ARB_IDLE && w_pick_vld) begin
                r_owner <= w_pick_id;
            end
            if (w_xfer_last) begin
                r_rr_ptr  <= (r_owner == C_LAST_ID) ? '0 : r_owner + 1'b1;
                r_pix_cnt <= '0;
                if (r_pix_cnt + 1'b1 != C_FRAME_LEN) begin
                    r_len_err <= 1'b1;
                end
            end else if (w_xfer) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
        end
    end

    relu_stage #(
        .DATA_W  (DATA_W)
`ifdef ACT_SAT_EN
        ,
        .SAT_MAX (SAT_MAX)
`endif
    ) u_relu (
        .i_pixel  (w_req_pix[r_owner]),
        .o_result (w_act_data)
    );

    // A transfer only happens when the register is empty or draining,
    // so loading here never overwrites an unaccepted result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_act_data;
            r_out_tag   <= r_owner;
            r_out_last  <= req_last[r_owner];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_tag    = r_out_tag;
    assign out_last   = r_out_last;
    assign len_err    = r_len_err;
    assign frame_done = r_out_valid && out_ready && r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_act_arbiter_ctrl.sv
// ============================================================================
// Module      : tb_act_arbiter_ctrl
// Description : Directed self-checking bench for act_arbiter_ctrl with a
//               requester model and output scoreboard. Honours ACT_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_act_arbiter_ctrl;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 22;
    localparam int FRAME_LEN = 1024;
    localparam int SAT_MAX   = 1000;
    localparam int TAG_W     = 2;
    localparam int ITEM_W    = DATA_W + TAG_W + 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ-1:0]         req_last  = '0;
    logic [DATA_W-1:0]        drv_pix [N_REQ];
    wire  [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_ready;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [DATA_W-1:0]        out_data;
    logic [TAG_W-1:0]         out_tag;
    logic                     out_last;
    logic                     frame_done;
    logic                     len_err;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign req_data[g*DATA_W +: DATA_W] = drv_pix[g];
    end

    act_arbiter_ctrl #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .SAT_MAX   (SAT_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_last   (out_last),
        .frame_done (frame_done),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Requester and scoreboard model
    int                 cnt [N_REQ];
    int                 flen [N_REQ];
    int                 frames_left [N_REQ];
    int                 gap_at [N_REQ];
    int                 gap_left [N_REQ];
    logic [ITEM_W-1:0]  sb_q [$];
    int                 grants [$];
    logic [DATA_W-1:0]  cap [$];
    logic [DATA_W-1:0]  vec [3];
    bit                 vec_mode;
    bit                 prev_fire, prev_stall, exp_len_err;
    logic [ITEM_W-1:0]  prev_item, prev_out;
    int                 cyc = 0;
    int                 stall_at, stall_left, consumed, done_pulses, last_fire_cyc, cur_owner;

    function automatic logic [DATA_W-1:0] pix_val(input int i, input int c);
        if (vec_mode && i == 0 && c < 3) return vec[c];
        if (c % 2 == 1) return DATA_W'(c + 6 + i * 4096);
        return DATA_W'(-(c + 5));
    endfunction

    function automatic logic [DATA_W-1:0] act_model(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1]) return '0;
`ifdef ACT_SAT_EN
        if (v > DATA_W'(SAT_MAX)) return DATA_W'(SAT_MAX);
`endif
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N_REQ; i++) begin
            cnt[i] = 0; flen[i] = FRAME_LEN; frames_left[i] = 0;
            gap_at[i] = 0; gap_left[i] = 0; drv_pix[i] = '0;
        end
        sb_q.delete(); grants.delete(); cap.delete();
        prev_fire = 0; prev_stall = 0; exp_len_err = 0; vec_mode = 0;
        stall_left = 0; stall_at = 0; consumed = 0; done_pulses = 0; cur_owner = -1;
    endtask

    task automatic new_test();
        grants.delete(); cap.delete();
        consumed = 0; done_pulses = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_len_err", len_err, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_tag", out_tag, 0);
        check_eq("rst_out_last", out_last, 0);
        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
        clear_model();
    endtask

    task automatic step();
        logic [N_REQ-1:0]  fire;
        logic [ITEM_W-1:0] obs, item;
        bit                consume, exp_fd;
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            drv_pix[i]   = '0;
            if (frames_left[i] > 0) begin
                if (gap_left[i] > 0 && cnt[i] == gap_at[i]) begin
                    gap_left[i]--;
                end else begin
                    req_valid[i] = 1'b1;
                    drv_pix[i]   = pix_val(i, cnt[i]);
                    req_last[i]  = (cnt[i] == flen[i] - 1);
                end
            end
        end
        out_ready = 1'b1;
        if (stall_left > 0 && cyc >= stall_at) begin
            out_ready = 1'b0;
            stall_left--;
        end
        #1;
        obs = {out_data, out_tag, out_last};
        if (prev_fire)  check_eq("latency", {out_valid, obs}, {1'b1, prev_item});
        if (prev_stall) check_eq("hold", {out_valid, obs}, {1'b1, prev_out});
        check_eq("len_err", len_err, exp_len_err);
        if (out_valid && !out_ready) check_eq("stall_ready", req_ready, 0);
        consume = out_valid && out_ready;
        exp_fd  = 1'b0;
        if (consume) begin
            check_eq("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                item = sb_q.pop_front();
                check_eq("pixel", obs, item);
                exp_fd = item[0];
            end
            consumed++;
            cap.push_back(out_data);
        end
        check_eq("frame_done", frame_done, exp_fd);
        if (frame_done) done_pulses++;
        fire = req_valid & req_ready;
        check_eq("one_fire", $countones(fire) <= 1, 1);
        prev_fire = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (fire[i]) begin
                if (cnt[i] == 0) begin
                    grants.push_back(i);
                    cur_owner = i;
                end else begin
                    check_eq("interleave", i, cur_owner);
                end
                item = {act_model(drv_pix[i]), TAG_W'(i), req_last[i]};
                sb_q.push_back(item);
                prev_item     = item;
                prev_fire     = 1;
                last_fire_cyc = cyc;
                if (req_last[i]) begin
                    if (cnt[i] + 1 != FRAME_LEN) exp_len_err = 1;
                    cnt[i] = 0;
                    frames_left[i]--;
                    flen[i] = FRAME_LEN;
                end else begin
                    cnt[i]++;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = obs;
        cyc++;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N_REQ; i++) if (frames_left[i] > 0) return 0;
        return sb_q.size() == 0;
    endfunction

    task automatic run(input string name, input int max_cyc);
        int k = 0;
        while (k < max_cyc && !all_done()) begin
            step();
            k++;
        end
        check_eq({name, "_in_time"}, k < max_cyc, 1);
    endtask

    int base_cyc;
    int exp_grants [$];
    int k5;

    initial begin
        clear_model();
        do_reset();

        // Single requester with a mid-frame gap and a 5-cycle downstream stall
        new_test();
        frames_left[2] = 1; gap_at[2] = 500; gap_left[2] = 3;
        stall_at = cyc + 200; stall_left = 5;
        run("t1", 3000);
        check_eq("t1_consumed", consumed, 1024);
        check_eq("t1_done_pulses", done_pulses, 1);
        check_eq("t1_len_err", len_err, 0);
        check_eq("t1_grant_cnt", grants.size(), 1);
        check_eq("t1_grant0", grants[0], 2);
        check_eq("t1_data0", cap[0], 0);
`ifdef ACT_SAT_EN
        check_eq("t1_data1", cap[1], 1000);
`else
        check_eq("t1_data1", cap[1], 8199);
`endif

        // All four requesters contending from reset
        do_reset();
        new_test();
        frames_left[0] = 2; frames_left[1] = 1; frames_left[2] = 1; frames_left[3] = 1;
        gap_at[0] = 500; gap_left[0] = 4;
        stall_at = cyc + 3000; stall_left = 5;
        run("t2", 8000);
        exp_grants = '{0, 1, 2, 3, 0};
        check_eq("t2_grant_cnt", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) check_eq("t2_grant", grants[i], exp_grants[i]);
        check_eq("t2_consumed", consumed, 5 * 1024);
        check_eq("t2_done_pulses", done_pulses, 5);

        // Short frame then a good frame on requester 1: len_err sticks
        new_test();
        frames_left[1] = 2; flen[1] = 1000;
        run("t4", 4000);
        check_eq("t4_len_err", len_err, 1);
        check_eq("t4_consumed", consumed, 2024);
        check_eq("t4_done_pulses", done_pulses, 2);

        // Reset in the middle of a frame
        new_test();
        frames_left[3] = 1;
        k5 = 0;
        while (cnt[3] < 300 && k5 < 2000) begin
            step();
            k5++;
        end
        check_eq("t5_reach_300", cnt[3], 300);
        do_reset();
        new_test();
        frames_left[1] = 1; frames_left[3] = 1;
        base_cyc = cyc;
        run("t5", 3000);
        check_eq("t5_grant_cnt", grants.size(), 2);
        check_eq("t5_grant0", grants[0], 1);
        check_eq("t5_grant1", grants[1], 3);
        check_eq("t5_cycles", last_fire_cyc - base_cyc + 1, 2 * (FRAME_LEN + 1));
        check_eq("t5_len_err", len_err, 0);

        // Activation corner values
        do_reset();
        new_test();
        vec_mode = 1;
        vec[0] = DATA_W'(2000); vec[1] = DATA_W'(999); vec[2] = '1;
        frames_left[0] = 1; flen[0] = 3;
        run("t6", 100);
        check_eq("t6_count", cap.size(), 3);
`ifdef ACT_SAT_EN
        check_eq("t6_d0", cap[0], 1000);
`else
        check_eq("t6_d0", cap[0], 2000);
`endif
        check_eq("t6_d1", cap[1], 999);
        check_eq("t6_d2", cap[2], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
